// File: rtl/store_write_buffer.sv
// In-order store buffer feeding a single-beat AXI write master; one write in flight,
// head entry held on cpu_* until the master returns to idle, then retired.
module store_write_buffer #(
    parameter int unsigned    DEPTH  = 4,
    parameter int unsigned    ADDR_W = 64,
    parameter int unsigned    DATA_W = 64,
    parameter int unsigned    ID_W   = 4,
    parameter logic [ID_W-1:0] WR_ID = 4'd1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [1:0]        st_size,
    input  logic [ADDR_W-1:0] ld_chk_addr,
    output logic              ld_chk_hit,
    output logic              sb_empty,
    output logic              wr_err,
    input  logic              wr_err_clr,
    output logic              cpu_aw_valid,
    input  logic              cpu_aw_ready,
    output logic [ID_W-1:0]   cpu_id,
    output logic [ADDR_W-1:0] cpu_addr,
    output logic [7:0]        cpu_aw_len,
    output logic [1:0]        cpu_size,
    output logic [DATA_W-1:0] cpu_w_data,
    input  logic [1:0]        cpu_w_resp
);

    localparam int unsigned PW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_BUSY = 2'd2;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [1:0]        r_size [DEPTH];

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic [1:0]    r_state;
    logic          r_wr_err;

    logic          w_push;
    logic          w_pop;
    logic [PW:0]   w_count_nxt;
    logic [1:0]    w_state_nxt;
    logic          w_hit;
    logic [PW-1:0] w_off;
    logic          w_unused_ok;

    assign w_push = st_valid && st_ready;
    assign w_pop  = (r_state == S_BUSY) && cpu_aw_ready;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + 1'b1;
        else if (w_pop && !w_push)
            w_count_nxt = r_count - 1'b1;
    end

    // BUSY decides REQ vs IDLE on the post-edge count, so a same-edge push keeps the pipe busy
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_count != '0) w_state_nxt = S_REQ;
            S_REQ:   if (cpu_aw_ready) w_state_nxt = S_BUSY;
            S_BUSY:  if (cpu_aw_ready) w_state_nxt = (w_count_nxt != '0) ? S_REQ : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_state  <= S_IDLE;
            r_wr_err <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_state <= w_state_nxt;
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            if (w_pop && (cpu_w_resp != 2'b00))
                r_wr_err <= 1'b1;
            else if (wr_err_clr)
                r_wr_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= st_addr;
            r_data[r_tail] <= st_data;
            r_size[r_tail] <= st_size;
        end
    end

    // Occupancy is judged by distance from head so the in-flight head entry is included
    always_comb begin
        w_hit = 1'b0;
        w_off = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_off = PW'(i) - r_head;
            if (({1'b0, w_off} < r_count) &&
                (r_addr[i][ADDR_W-1:3] == ld_chk_addr[ADDR_W-1:3]))
                w_hit = 1'b1;
        end
    end

    assign w_unused_ok = &{1'b0, ld_chk_addr[2:0]};

    assign st_ready     = (r_count != (PW+1)'(DEPTH));
    assign ld_chk_hit   = w_hit;
    assign sb_empty     = (r_count == '0) && (r_state != S_BUSY);
    assign wr_err       = r_wr_err;
    assign cpu_aw_valid = (r_state == S_REQ);
    assign cpu_id       = WR_ID;
    assign cpu_aw_len   = 8'd0;
    assign cpu_addr     = r_addr[r_head];
    assign cpu_size     = r_size[r_head];
    assign cpu_w_data   = r_data[r_head];

endmodule
